// File: rtl/fns_seq_encoder.sv
// Sequential FNS encoder: greedy lane-by-lane subtraction of snapshotted weights, MSB lane first.
// Optional macro FNS_ENC_EARLY_EXIT_EN finishes as soon as the remainder reaches zero.
module fns_seq_encoder #(
    parameter int N_TSV = 9,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_TSV-1:0]    en_flag,
    input  logic [N_TSV*DW-1:0] weight,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       data_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_TSV-1:0]    code_out,
    output logic                err_out,
    output logic [1:0]          state_dbg_o
);

    localparam int IW = (N_TSV > 1) ? $clog2(N_TSV) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(N_TSV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and DONE holds code/err until out_ready is seen.
    state_e              state_q;
    logic [N_TSV-1:0]    en_q;
    logic [N_TSV*DW-1:0] w_q;
    logic [DW-1:0]       rem_q;
    logic [IW-1:0]       idx_q;
    logic [N_TSV-1:0]    code_q;
    logic [N_TSV-1:0]    code_out_q;
    logic                err_q;
    logic                out_valid_q;

    logic [DW-1:0]       w_lane;
    logic                hit;
    logic [DW-1:0]       rem_d;
    logic [N_TSV-1:0]    code_d;
    logic                exit_now;

    always_comb begin
        w_lane = w_q[int'(idx_q)*DW +: DW];
        hit    = en_q[idx_q] && (rem_q >= w_lane);
`ifdef FNS_ENC_EARLY_EXIT_EN
        // A zero remainder means the word is already fully encoded; touch no more lanes.
        if (rem_q == '0) begin
            hit = 1'b0;
        end
`endif
        rem_d  = hit ? (rem_q - w_lane) : rem_q;
        code_d = code_q;
        code_d[idx_q] = hit;
`ifdef FNS_ENC_EARLY_EXIT_EN
        exit_now = (idx_q == '0) || (rem_d == '0);
`else
        exit_now = (idx_q == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            en_q        <= '0;
            w_q         <= '0;
            rem_q       <= '0;
            idx_q       <= IDX_TOP;
            code_q      <= '0;
            code_out_q  <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        en_q    <= en_flag;
                        w_q     <= weight;
                        rem_q   <= data_in;
                        code_q  <= '0;
                        idx_q   <= IDX_TOP;
                        state_q <= ENC;
                    end
                end
                ENC: begin
                    rem_q  <= rem_d;
                    code_q <= code_d;
                    idx_q  <= idx_q - IW'(1);
                    if (exit_now) begin
                        code_out_q  <= code_d;
                        err_q       <= (rem_d != '0);
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Gated with rst_n so nothing is offered as accepted while reset is held.
    assign in_ready    = (state_q == IDLE) && rst_n;
    assign out_valid   = out_valid_q;
    assign code_out    = code_out_q;
    assign err_out     = err_q;
    assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fns_seq_encoder.sv
// Directed table-driven bench for fns_seq_encoder (N_TSV=9, DW=8, Fibonacci weights).
module tb_fns_seq_encoder;

    localparam int N  = 9;
    localparam int DW = 8;
`ifdef FNS_ENC_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam logic [N*DW-1:0] FIB_W =
        {8'd55, 8'd34, 8'd21, 8'd13, 8'd8, 8'd5, 8'd3, 8'd2, 8'd1};

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    en_flag = '1;
    logic [N*DW-1:0] weight = FIB_W;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [DW-1:0]   data_in = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [N-1:0]    code_out;
    logic            err_out;
    logic [1:0]      state_dbg;

    int n_vec = 0;
    int n_err = 0;

    fns_seq_encoder #(.N_TSV(N), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en_flag(en_flag), .weight(weight),
        .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
        .out_valid(out_valid), .out_ready(out_ready), .code_out(code_out),
        .err_out(err_out), .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] en;
        logic [DW-1:0] data;
        logic [N-1:0] exp_code;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sends one word, measures latency, optionally zeroes weights/enables mid-flight,
    // holds out_ready low for 'hold' cycles, then completes the output transfer.
    task automatic run_word(input string tag, input logic [N-1:0] en, input logic [N*DW-1:0] w,
                            input logic [DW-1:0] data, input logic [N-1:0] exp_code,
                            input logic exp_err, input int exp_lat, input int change_at,
                            input int hold);
        int lat;
        en_flag  = en;
        weight   = w;
        data_in  = data;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        data_in  = $urandom_range(0, 255);
        check({tag, " busy_in_ready"}, int'(in_ready), 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == change_at) begin
                weight  = '0;
                en_flag = '0;
            end
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " code"}, int'(code_out), int'(exp_code));
        check({tag, " err"}, int'(err_out), int'(exp_err));
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            check({tag, " hold_valid"}, int'(out_valid), 1);
            check({tag, " hold_code"}, int'(code_out), int'(exp_code));
            check({tag, " hold_err"}, int'(err_out), int'(exp_err));
            check({tag, " hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, " post_valid"}, int'(out_valid), 0);
        check({tag, " post_in_ready"}, int'(in_ready), 1);
        check({tag, " post_code_kept"}, int'(code_out), int'(exp_code));
        en_flag = '1;
        weight  = FIB_W;
    endtask

    initial begin
        vecs[0] = '{9'h1FF, 8'd100, 9'h194, 1'b0, EE ? 7 : 9};
        vecs[1] = '{9'h1FF, 8'd200, 9'h1FF, 1'b1, 9};
        vecs[2] = '{9'h1F7, 8'd5,   9'h006, 1'b0, EE ? 8 : 9};
        vecs[3] = '{9'h1FF, 8'd0,   9'h000, 1'b0, EE ? 1 : 9};
        vecs[4] = '{9'h1FF, 8'd142, 9'h1FF, 1'b0, 9};
        vecs[5] = '{9'h000, 8'd7,   9'h000, 1'b1, 9};
        vecs[6] = '{9'h1FF, 8'd1,   9'h001, 1'b0, 9};
        vecs[7] = '{9'h1FF, 8'd55,  9'h100, 1'b0, EE ? 1 : 9};
        vecs[8] = '{9'h0FF, 8'd100, 9'h0FF, 1'b1, 9};
        vecs[9] = '{9'h1FF, 8'd255, 9'h1FF, 1'b1, 9};

        // Reset state
        #12;
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_code", int'(code_out), 0);
        check("rst_err", int'(err_out), 0);
        check("rst_state", int'(state_dbg), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", int'(in_ready), 1);

        for (int i = 0; i < 10; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].en, FIB_W, vecs[i].data,
                     vecs[i].exp_code, vecs[i].exp_err, vecs[i].exp_lat, -1, 0);
        end

        // Weights and enables wiped two cycles after acceptance must not matter
        run_word("snapshot", 9'h1FF, FIB_W, 8'd100, 9'h194, 1'b0, EE ? 7 : 9, 2, 0);

        // Back-pressure: out_ready low for 5 cycles in DONE
        run_word("backpressure", 9'h1FF, FIB_W, 8'd200, 9'h1FF, 1'b1, 9, -1, 5);

        // Reset during the 4th ENC step discards the word (code_out currently 0x1FF)
        en_flag  = '1;
        weight   = FIB_W;
        data_in  = 8'd100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_code", int'(code_out), 0);
        check("midrst_err", int'(err_out), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_state", int'(state_dbg), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("midrst_release_in_ready", int'(in_ready), 1);
        begin
            int stale = 0;
            repeat (15) begin
                @(posedge clk); #1;
                if (out_valid) stale++;
            end
            check("midrst_no_stale_output", stale, 0);
        end
        run_word("after_rst", 9'h1F7, FIB_W, 8'd5, 9'h006, 1'b0, EE ? 8 : 9, -1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fns_seq_encoder.md
FNS_SEQ_ENCODER -- requirements
Module: fns_seq_encoder

Interface
REQ-001 Parameter N_TSV, default 9, number of TSV lanes (lane 0 = first TSV).
REQ-002 Parameter DW, default 8, data and per-lane weight width.
REQ-003 clk  input  1  single clock, all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 en_flag  input  N_TSV  lane enable from the FNS adder stage; 1 = lane usable.
REQ-006 weight  input  N_TSV*DW  flat FNS weight per lane; lane i occupies bits [i*DW +: DW].
REQ-007 in_valid / in_ready  input / output  1 / 1  data-word handshake.
REQ-008 data_in  input  DW  binary value to encode.
REQ-009 out_valid / out_ready  output / input  1 / 1  codeword handshake.
REQ-010 code_out  output  N_TSV  FNS codeword, one bit per TSV lane.
REQ-011 err_out  output  1  value not representable with the enabled weights.

Function
REQ-012 The FSM SHALL have states IDLE, ENC and DONE; in_ready = 1 only in IDLE.
REQ-013 An input transfer occurs on an edge with in_valid=1 and in_ready=1; it snapshots en_flag, weight and data_in (as remainder rem), clears the code register and sets the lane index to N_TSV-1.
REQ-014 After acceptance, later changes to en_flag or weight SHALL NOT affect the word in flight.
REQ-015 In ENC, each edge processes one lane i, descending from N_TSV-1 to 0: if en[i]=1 and rem >= w[i], then code[i]=1 and rem = rem - w[i]; otherwise code[i]=0.
REQ-016 A disabled lane SHALL produce code bit 0 whatever its weight value; the subtraction is DW wide and never underflows.
REQ-017 After lane 0 is processed, the FSM SHALL enter DONE with err_out = (rem != 0).
REQ-018 In DONE, out_valid=1 and code_out/err_out are held stable until the edge with out_ready=1; the FSM then returns to IDLE.
REQ-019 Base latency: out_valid is asserted after exactly N_TSV rising edges following the acceptance edge.
REQ-020 Back-pressure: while out_ready=0 in DONE, no new word is accepted and the outputs do not change.
REQ-021 Minimum throughput: one word per N_TSV+2 cycles (accept, N_TSV steps, output transfer).
REQ-022 Outside DONE, out_valid=0; code_out and err_out keep their last value.

Reset
REQ-023 rst_n=0 SHALL immediately force IDLE, with code_out=0, err_out=0, out_valid=0, rem=0 and index=N_TSV-1.
REQ-024 In IDLE after reset, in_ready=1; in_ready is 0 while rst_n=0.
REQ-025 Reset asserted mid-ENC or in DONE SHALL discard the in-flight word; no output transfer follows.

Configuration
REQ-026 Macro FNS_ENC_EARLY_EXIT_EN: when defined, if rem becomes 0 after any ENC step (or data_in=0 at acceptance), the FSM enters DONE on that same edge; unprocessed code bits stay 0 and err_out=0.
REQ-027 With FNS_ENC_EARLY_EXIT_EN defined, a word with data_in=0 gives out_valid one edge after acceptance.
REQ-028 Without the macro, latency is always N_TSV edges (REQ-019).

Verification
REQ-029 All lanes enabled, weights lane0..8 = 1,2,3,5,8,13,21,34,55, data_in=100 -> code_out=9'h194, err_out=0; out_valid after 9 edges (7 edges with FNS_ENC_EARLY_EXIT_EN).
REQ-030 Same weights, data_in=200 -> code_out=9'h1FF, err_out=1 (remainder 58).
REQ-031 en_flag=9'b111110111 (lane 3 disabled), same weights, data_in=5 -> code_out=9'h006, err_out=0.
REQ-032 weight changed to all-zero 2 cycles after acceptance of data_in=100 -> result identical to REQ-029.
REQ-033 out_ready held 0 for 5 cycles in DONE -> out_valid, code_out and err_out stable, in_ready=0; transfer on the 6th cycle, in_ready=1 on the next cycle.
REQ-034 rst_n pulsed low during the 4th ENC step -> out_valid=0 and code_out=0 at once, in_ready=1 after release, and no stale output appears.
